// File: rtl/clint_ctrl_pkg.sv
// Shared constants for the core-local trap controller: trap opcodes,
// cause codes, CSR addresses and the sequencing state encoding.
package clint_ctrl_pkg;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [31:0] CAUSE_ECALL_M = 32'h0000_000B;
    localparam logic [31:0] CAUSE_EBREAK  = 32'h0000_0003;
    localparam logic [31:0] CAUSE_TIMER_M = 32'h8000_0007;
    localparam logic [31:0] CAUSE_EXT_M   = 32'h8000_000B;

    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_W_MEPC      = 3'd1,
        S_W_MSTATUS   = 3'd2,
        S_W_MCAUSE    = 3'd3,
        S_ASSERT      = 3'd4,
        S_W_MRET      = 3'd5,
        S_MRET_ASSERT = 3'd6
    } state_t;

endpackage

// File: rtl/clint_ctrl.sv
// Core-local trap controller: detects ecall/ebreak/mret and level interrupts in ID,
// stalls the pipeline, sequences mepc/mstatus/mcause writes and redirects the PC.
module clint_ctrl
    import clint_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       inst_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              hold_flag_i,
    input  logic [7:0]        int_flag_i,
    input  logic              global_int_en_i,
    input  logic [DATA_W-1:0] csr_mtvec_i,
    input  logic [DATA_W-1:0] csr_mepc_i,
    input  logic [DATA_W-1:0] csr_mstatus_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              hold_flag_o,
    output logic              int_assert_o,
    output logic [ADDR_W-1:0] int_addr_o
);

    state_t              r_state;
    logic [DATA_W-1:0]   r_cause;
    logic [ADDR_W-1:0]   r_epc;

    logic                w_can_detect;
    logic                w_is_mret;
    logic                w_is_trap;
    logic                w_detect;
    logic [DATA_W-1:0]   w_cause;
    logic [ADDR_W-1:0]   w_epc;

    // Priority encoder: mret > ecall > ebreak > async interrupt.
    // Detection is gated by reset so every output reads 0 while reset is held.
    always_comb begin
        w_can_detect = (r_state == S_IDLE) && !hold_flag_i && !rst_n;
        w_is_mret    = 1'b0;
        w_is_trap    = 1'b0;
        w_cause      = '0;
        w_epc        = inst_addr_i;
        if (inst_i == INST_MRET) begin
            w_is_mret = 1'b1;
        end else if (inst_i == INST_ECALL) begin
            w_is_trap = 1'b1;
            w_cause   = DATA_W'(CAUSE_ECALL_M);
        end else if (inst_i == INST_EBREAK) begin
            w_is_trap = 1'b1;
            w_cause   = DATA_W'(CAUSE_EBREAK);
        end else if (global_int_en_i && (int_flag_i != 8'h00)) begin
            w_is_trap = 1'b1;
            w_cause   = int_flag_i[0] ? DATA_W'(CAUSE_TIMER_M) : DATA_W'(CAUSE_EXT_M);
            w_epc     = jump_flag_i ? jump_addr_i : inst_addr_i;
        end
        w_detect = w_can_detect && (w_is_mret || w_is_trap);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= S_IDLE;
            r_cause <= '0;
            r_epc   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_can_detect && w_is_mret) begin
                        r_state <= S_W_MRET;
                    end else if (w_can_detect && w_is_trap) begin
                        r_state <= S_W_MEPC;
                        r_cause <= w_cause;
                        r_epc   <= w_epc;
                    end
                end
                S_W_MEPC:      r_state <= S_W_MSTATUS;
                S_W_MSTATUS:   r_state <= S_W_MCAUSE;
                S_W_MCAUSE:    r_state <= S_ASSERT;
                S_ASSERT:      r_state <= S_IDLE;
                S_W_MRET:      r_state <= S_MRET_ASSERT;
                S_MRET_ASSERT: r_state <= S_IDLE;
                default:       r_state <= S_IDLE;
            endcase
        end
    end

    // Write port and redirect are decoded from the current state; mstatus
    // updates are applied to the live CSR value so other fields pass through.
    always_comb begin
        we_o         = 1'b0;
        waddr_o      = '0;
        data_o       = '0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;
        case (r_state)
            S_W_MEPC: begin
                we_o    = 1'b1;
                waddr_o = {{(ADDR_W-12){1'b0}}, CSR_MEPC};
                data_o  = DATA_W'(r_epc);
            end
            S_W_MSTATUS: begin
                we_o      = 1'b1;
                waddr_o   = {{(ADDR_W-12){1'b0}}, CSR_MSTATUS};
                data_o    = csr_mstatus_i;
                data_o[7] = csr_mstatus_i[3];
                data_o[3] = 1'b0;
            end
            S_W_MCAUSE: begin
                we_o    = 1'b1;
                waddr_o = {{(ADDR_W-12){1'b0}}, CSR_MCAUSE};
                data_o  = r_cause;
            end
            S_ASSERT: begin
                int_assert_o = 1'b1;
                int_addr_o   = ADDR_W'(csr_mtvec_i);
            end
            S_W_MRET: begin
                we_o      = 1'b1;
                waddr_o   = {{(ADDR_W-12){1'b0}}, CSR_MSTATUS};
                data_o    = csr_mstatus_i;
                data_o[3] = csr_mstatus_i[7];
                data_o[7] = 1'b1;
            end
            S_MRET_ASSERT: begin
                int_assert_o = 1'b1;
                int_addr_o   = ADDR_W'(csr_mepc_i);
            end
            default: ;
        endcase
    end

    assign hold_flag_o = (r_state != S_IDLE) || w_detect;

endmodule

// File: tb/tb_clint_ctrl.sv
// Directed bench for clint_ctrl: trap and mret sequences, interrupt gating,
// hold suppression and mid-sequence reset, checked with immediate assertions.
module tb_clint_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_i;
    logic [7:0]  int_flag_i;
    logic        global_int_en_i;
    logic [31:0] csr_mtvec_i;
    logic [31:0] csr_mepc_i;
    logic [31:0] csr_mstatus_i;
    logic        we_o;
    logic [31:0] waddr_o;
    logic [31:0] data_o;
    logic        hold_flag_o;
    logic        int_assert_o;
    logic [31:0] int_addr_o;

    int total = 0;
    int bad   = 0;

    clint_ctrl #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .inst_i          (inst_i),
        .inst_addr_i     (inst_addr_i),
        .jump_flag_i     (jump_flag_i),
        .jump_addr_i     (jump_addr_i),
        .hold_flag_i     (hold_flag_i),
        .int_flag_i      (int_flag_i),
        .global_int_en_i (global_int_en_i),
        .csr_mtvec_i     (csr_mtvec_i),
        .csr_mepc_i      (csr_mepc_i),
        .csr_mstatus_i   (csr_mstatus_i),
        .we_o            (we_o),
        .waddr_o         (waddr_o),
        .data_o          (data_o),
        .hold_flag_o     (hold_flag_o),
        .int_assert_o    (int_assert_o),
        .int_addr_o      (int_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller sets inputs for cycle T shortly after a rising edge, then calls this.
    // Software-visible MIE drops once mstatus is written, so gie is cleared at T+1.
    task automatic trap_seq(input string tag, input logic [31:0] epc, input logic [31:0] st,
                            input logic [31:0] cause, input logic [31:0] vec);
        #1;
        chk({tag, ".T.hold"}, hold_flag_o, 1);
        chk({tag, ".T.we"}, we_o, 0);
        tick();
        inst_i = NOP;
        global_int_en_i = 1'b0;
        chk({tag, ".mepc.we"}, we_o, 1);
        chk({tag, ".mepc.addr"}, waddr_o, 32'h341);
        chk({tag, ".mepc.data"}, data_o, epc);
        chk({tag, ".mepc.hold"}, hold_flag_o, 1);
        tick();
        chk({tag, ".mstatus.addr"}, waddr_o, 32'h300);
        chk({tag, ".mstatus.data"}, data_o, st);
        chk({tag, ".mstatus.hold"}, hold_flag_o, 1);
        tick();
        chk({tag, ".mcause.addr"}, waddr_o, 32'h342);
        chk({tag, ".mcause.data"}, data_o, cause);
        tick();
        chk({tag, ".assert"}, int_assert_o, 1);
        chk({tag, ".assert.addr"}, int_addr_o, vec);
        chk({tag, ".assert.we"}, we_o, 0);
        chk({tag, ".assert.hold"}, hold_flag_o, 1);
        tick();
        chk({tag, ".idle.hold"}, hold_flag_o, 0);
        chk({tag, ".idle.assert"}, int_assert_o, 0);
        $display("txn %s: epc=%h mstatus=%h cause=%h vec=%h", tag, epc, st, cause, vec);
    endtask

    task automatic mret_seq(input string tag, input logic [31:0] st, input logic [31:0] epc);
        #1;
        chk({tag, ".T.hold"}, hold_flag_o, 1);
        tick();
        inst_i = NOP;
        chk({tag, ".mstatus.we"}, we_o, 1);
        chk({tag, ".mstatus.addr"}, waddr_o, 32'h300);
        chk({tag, ".mstatus.data"}, data_o, st);
        tick();
        chk({tag, ".assert"}, int_assert_o, 1);
        chk({tag, ".assert.addr"}, int_addr_o, epc);
        chk({tag, ".assert.we"}, we_o, 0);
        tick();
        chk({tag, ".idle.hold"}, hold_flag_o, 0);
        $display("txn %s: mstatus=%h target=%h", tag, st, epc);
    endtask

    initial begin
        rst_n = 1'b1;
        inst_i = NOP;
        inst_addr_i = 32'h8000_0000;
        jump_flag_i = 1'b0;
        jump_addr_i = '0;
        hold_flag_i = 1'b0;
        int_flag_i = 8'h00;
        global_int_en_i = 1'b0;
        csr_mtvec_i = 32'h8000_0100;
        csr_mepc_i = '0;
        csr_mstatus_i = 32'h0000_0008;
        #2;
        chk("reset.we", we_o, 0);
        chk("reset.hold", hold_flag_o, 0);
        chk("reset.assert", int_assert_o, 0);
        chk("reset.waddr", waddr_o, 0);
        repeat (2) tick();
        rst_n = 1'b0;
        tick();

        // ecall
        inst_i = 32'h0000_0073;
        inst_addr_i = 32'h8000_0010;
        trap_seq("ecall", 32'h8000_0010, 32'h0000_0080, 32'h0000_000B, 32'h8000_0100);

        // mret
        csr_mstatus_i = 32'h0000_0080;
        csr_mepc_i = 32'h8000_0014;
        inst_i = 32'h3020_0073;
        inst_addr_i = 32'h8000_0014;
        mret_seq("mret", 32'h0000_0088, 32'h8000_0014);

        // timer interrupt during an EX redirect
        csr_mstatus_i = 32'h0000_0008;
        inst_addr_i = 32'h8000_0020;
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h8000_0200;
        int_flag_i = 8'h01;
        global_int_en_i = 1'b1;
        trap_seq("timer", 32'h8000_0200, 32'h0000_0080, 32'h8000_0007, 32'h8000_0100);
        jump_flag_i = 1'b0;
        #1;
        chk("timer_masked.hold", hold_flag_o, 0);
        tick();
        chk("timer_masked.we", we_o, 0);
        chk("timer_masked.hold2", hold_flag_o, 0);
        int_flag_i = 8'h00;

        // ebreak with a coincident external interrupt
        global_int_en_i = 1'b1;
        inst_i = 32'h0010_0073;
        inst_addr_i = 32'h8000_0030;
        int_flag_i = 8'h04;
        trap_seq("ebreak", 32'h8000_0030, 32'h0000_0080, 32'h0000_0003, 32'h8000_0100);
        tick();
        chk("ext_pending.hold", hold_flag_o, 0);
        chk("ext_pending.we", we_o, 0);
        csr_mstatus_i = 32'h0000_0080;
        csr_mepc_i = 32'h8000_0034;
        inst_i = 32'h3020_0073;
        mret_seq("mret2", 32'h0000_0088, 32'h8000_0034);
        csr_mstatus_i = 32'h0000_0008;
        global_int_en_i = 1'b1;
        inst_addr_i = 32'h8000_0034;
        trap_seq("ext", 32'h8000_0034, 32'h0000_0080, 32'h8000_000B, 32'h8000_0100);
        int_flag_i = 8'h00;

        // ecall held off by an external stall, then released
        inst_i = 32'h0000_0073;
        inst_addr_i = 32'h8000_0040;
        hold_flag_i = 1'b1;
        #1;
        chk("held.hold", hold_flag_o, 0);
        tick();
        chk("held.hold2", hold_flag_o, 0);
        chk("held.we", we_o, 0);
        hold_flag_i = 1'b0;
        trap_seq("released", 32'h8000_0040, 32'h0000_0080, 32'h0000_000B, 32'h8000_0100);

        // reset in the middle of a trap sequence
        inst_i = 32'h0000_0073;
        inst_addr_i = 32'h8000_0050;
        #1;
        chk("abort.T.hold", hold_flag_o, 1);
        tick();
        inst_i = NOP;
        tick();
        chk("abort.mstatus.addr", waddr_o, 32'h300);
        rst_n = 1'b1;
        #1;
        chk("abort.we", we_o, 0);
        chk("abort.waddr", waddr_o, 0);
        chk("abort.data", data_o, 0);
        chk("abort.hold", hold_flag_o, 0);
        chk("abort.assert", int_assert_o, 0);
        tick();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort.after.we", we_o, 0);
            chk("abort.after.assert", int_assert_o, 0);
        end
        $display("txn abort: reset during mstatus write");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
